// File: rtl/seq_divider_pkg.sv
// Purpose: shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_div_pkg;

    // Controller states: IDLE waits for start, LOAD inspects the captured
    // divisor, CALC runs one quotient bit per clock, DONE presents the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Default operand width; the design supports 2..16.
    localparam int DEFAULT_WIDTH = 4;

    // Iteration counter width for the default operand width. It only has to
    // reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Purpose: operand/result bundle between a control unit and seq_divider.
// Latency: n/a (wiring only).
// Backpressure: start/done handshake; start is ignored unless the divider is idle.
// Ports (signals):
//   start, dividend, divisor              control unit -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                           divider -> control unit
interface seq_divider_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Control unit side.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_aq_register.sv
// Purpose: A:Q register pair of the restoring divider; shifts left and conditionally restores.
// Latency: one quotient bit per clock while shift_sub is high; load takes one clock.
// Backpressure: none; the controller decides when to load or iterate.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             A <= 0, Q <= dividend
//   shift_sub        perform one shift/subtract/restore iteration against m
//   dividend, m      operand values (m is the captured divisor)
//   a, q             current register contents
//   a_step, q_step   values a and q will take if an iteration is done this cycle
//                    (lets the controller capture the final result on the last edge)
module div_aq_register
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_sub,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] a_step,
    output logic [WIDTH-1:0] q_step
);

    logic [WIDTH:0]   a_shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    // {A,Q} << 1: A always stays below M between iterations, so its MSB is
    // zero and dropping it in the shift loses nothing.
    assign a_shifted = {a[WIDTH-1:0], q[WIDTH-1]};

    // WIDTH+1-bit trial subtract; the MSB is the borrow.
    assign trial = a_shifted - {1'b0, m};

    always_comb begin
        a_next = a_shifted;
        q_next = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            a_next = trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

    assign a_step = a_next[WIDTH-1:0];
    assign q_step = q_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            q <= '0;
        end else if (load) begin
            a <= '0;
            q <= dividend;
        end else if (shift_sub) begin
            a <= a_next;
            q <= q_next;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Purpose: sequential unsigned restoring divider (controller, counter, result registers).
// Latency: done in the WIDTH+2nd cycle after the start edge (2nd cycle for a zero divisor).
// Backpressure: start is only accepted in IDLE; it is ignored (not queued) while busy or done.
// Ports:
//   clk, rst   clock, synchronous active-high reset (wins over everything, even mid-CALC)
//   bus        seq_divider_if.slave: start/dividend/divisor in;
//              busy/done/quotient/remainder/div_by_zero out
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] m_q;

    logic             load;
    logic             shift_sub;
    logic             last_iter;
    logic             m_zero;

    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] q_step;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // The A register is only consumed through a_step; its full value is kept
    // visible on a named net for waveform debugging.
    logic             unused_a;
    assign unused_a = ^a_q;

    assign load      = (state_q == IDLE) && bus.start;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign m_zero    = (m_q == '0);

    div_aq_register #(
        .WIDTH (WIDTH)
    ) u_aq (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_sub (shift_sub),
        .dividend  (bus.dividend),
        .m         (m_q),
        .a         (a_q),
        .q         (q_q),
        .a_step    (a_step),
        .q_step    (q_step)
    );

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        shift_sub = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                state_d = m_zero ? DONE : CALC;
            end
            CALC: begin
                shift_sub = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divisor capture and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            m_q   <= bus.divisor;
            cnt_q <= '0;
        end else if (shift_sub) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers are written on the edge that enters DONE and then hold
    // until the next result, so a new start does not disturb them. The normal
    // path captures the post-iteration values because A:Q updates on the same
    // edge. On the zero-divide path Q still holds the untouched dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if ((state_q == LOAD) && m_zero) begin
            quotient_q  <= '1;
            remainder_q <= q_q;
            dbz_q       <= 1'b1;
        end else if (shift_sub && last_iter) begin
            quotient_q  <= q_step;
            remainder_q <= a_step;
            dbz_q       <= 1'b0;
        end
    end

    assign bus.busy        = (state_q == LOAD) || (state_q == CALC);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
